// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller that feeds the F/D pipeline register.
// Keeps at most one fetch in flight, parks an early response in a one-entry skid
// buffer while decode stalls, and applies branch/jump redirects after the delay slot.
module fetch_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic [1:0]  pcsrc_d,
  input  logic [31:0] br_target_d,
  input  logic [31:0] j_target_d,
  input  logic [31:0] jr_target_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic        valid_f
);

  localparam logic [31:0] ResetPc = 32'h0000_3000;

  typedef enum logic [1:0] {StIssue, StWait, StSkid, StDrain} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        redir_pend_q;
  logic [31:0] redir_addr_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc_q;
  logic [31:0] instr_f_q;
  logic [31:0] pc_f_q;
  logic        valid_f_q;

  logic        capture;
  logic        squash;
  logic [31:0] target;

  // Redirect decode: a non-sequential decision is taken only on an edge where D advances.
  always_comb begin
    target = br_target_d;
    unique case (pcsrc_d)
      2'b10:   target = j_target_d;
      2'b11:   target = jr_target_d;
      default: target = br_target_d;
    endcase
  end

  assign capture = (pcsrc_d != 2'b00) && !stall_i;
  // Delay slot is leaving F/D on this edge, so whatever is being fetched is wrong-path.
  assign squash  = capture && valid_f_q;

  // Fetch FSM, PC/redirect bookkeeping, skid buffer and F/D register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIssue;
      pc_q         <= ResetPc;
      redir_pend_q <= 1'b0;
      redir_addr_q <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      instr_f_q    <= '0;
      pc_f_q       <= '0;
      valid_f_q    <= 1'b0;
    end else begin
      // D consumes the F/D entry; a load below overrides this.
      if (valid_f_q && !stall_i) begin
        valid_f_q <= 1'b0;
      end
      // Delay slot not fetched yet: remember the target until its fetch is accepted.
      if (capture && !valid_f_q) begin
        redir_pend_q <= 1'b1;
        redir_addr_q <= target;
      end

      unique case (state_q)
        StIssue: begin
          if (squash) begin
            pc_q    <= target;
            state_q <= StDrain;
          end else begin
            state_q <= StWait;
          end
        end

        StWait: begin
          if (squash) begin
            pc_q    <= target;
            state_q <= imem_ack ? StIssue : StDrain;
          end else if (imem_ack) begin
            if (capture) begin
              // Redirect arriving with the delay-slot data applies immediately.
              pc_q         <= target;
              redir_pend_q <= 1'b0;
            end else if (redir_pend_q) begin
              pc_q         <= redir_addr_q;
              redir_pend_q <= 1'b0;
            end else begin
              pc_q <= pc_q + 32'd4;
            end
            if (!valid_f_q || !stall_i) begin
              instr_f_q <= imem_rdata;
              pc_f_q    <= pc_q;
              valid_f_q <= 1'b1;
              state_q   <= StIssue;
            end else begin
              skid_instr_q <= imem_rdata;
              skid_pc_q    <= pc_q;
              state_q      <= StSkid;
            end
          end
        end

        StSkid: begin
          if (squash) begin
            // Skid entry is wrong-path; it is simply never moved into F/D.
            pc_q    <= target;
            state_q <= StIssue;
          end else if (!stall_i) begin
            instr_f_q <= skid_instr_q;
            pc_f_q    <= skid_pc_q;
            valid_f_q <= 1'b1;
            state_q   <= StIssue;
          end
        end

        StDrain: begin
          if (squash) begin
            pc_q <= target;
          end
          if (imem_ack) begin
            state_q <= StIssue;
          end
        end

        default: state_q <= StIssue;
      endcase
    end
  end

  // The FSM rests in StIssue during reset, so the request is masked until release.
  assign imem_req  = reset_n && (state_q == StIssue);
  assign imem_addr = pc_q;
  assign instr_f   = instr_f_q;
  assign pc_f      = pc_f_q;
  assign valid_f   = valid_f_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus a randomized run whose delivered instruction
// stream is compared against program order with delay-slot semantics.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall_i = 1'b0;
  logic [1:0]  pcsrc_d = 2'b00;
  logic [31:0] br_target_d = '0;
  logic [31:0] j_target_d = '0;
  logic [31:0] jr_target_d = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic        valid_f;

  int checks = 0;
  int failures = 0;

  // Memory model state (written only by the memory process) and manual override.
  bit          mem_manual = 1'b0;
  int          mem_lat = 1;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        mdl_ack = 1'b0;
  logic [31:0] mdl_rdata = '0;
  bit          mdl_busy = 1'b0;
  int          mdl_cnt = 0;
  logic [31:0] mdl_addr = '0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall_i     (stall_i),
    .pcsrc_d     (pcsrc_d),
    .br_target_d (br_target_d),
    .j_target_d  (j_target_d),
    .jr_target_d (jr_target_d),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_f     (instr_f),
    .pc_f        (pc_f),
    .valid_f     (valid_f)
  );

  assign imem_ack   = mem_manual ? man_ack : mdl_ack;
  assign imem_rdata = mem_manual ? man_rdata : mdl_rdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // Memory: a request seen before an edge is answered mem_lat cycles later (0 = random 1..3).
  always @(negedge clk) begin
    if (!reset_n) begin
      mdl_busy = 1'b0;
      mdl_ack  = 1'b0;
    end else begin
      mdl_ack   = 1'b0;
      mdl_rdata = $urandom;
      if (mdl_busy) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          mdl_ack   = 1'b1;
          mdl_rdata = mem_word(mdl_addr);
          mdl_busy  = 1'b0;
        end
      end
      if (imem_req === 1'b1) begin
        mdl_busy = 1'b1;
        mdl_addr = imem_addr;
        mdl_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_src(input int src, input logic [31:0] tgt);
    br_target_d = $urandom;
    j_target_d  = $urandom;
    jr_target_d = $urandom;
    pcsrc_d     = 2'(src);
    if (src == 1) br_target_d = tgt;
    if (src == 2) j_target_d = tgt;
    if (src == 3) jr_target_d = tgt;
  endtask

  // Reset, then release mid-high-phase so the next negedge sees the first request.
  task automatic do_reset(input int lat);
    @(posedge clk);
    #1;
    reset_n    = 1'b0;
    stall_i    = 1'b0;
    pcsrc_d    = 2'b00;
    mem_manual = 1'b0;
    man_ack    = 1'b0;
    mem_lat    = lat;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b0 || valid_f !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: req=%b valid=%b, required 0 0", imem_req, valid_f);
    end
    checks++;
    if (pc_f !== 32'h0 || instr_f !== 32'h0) begin
      failures++;
      $display("FAIL reset_fd: pc_f=%h instr_f=%h, required 0 0", pc_f, instr_f);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      failures++;
      $display("FAIL reset_first_req: req=%b addr=%h, required 1 00003000", imem_req, imem_addr);
    end
  endtask

  task automatic test_seq();
    bit          ereq[9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
    logic [31:0] eadr[9] = '{32'h3000, 0, 32'h3004, 0, 32'h3008, 0, 32'h300C, 0, 32'h3010};
    bit          evld[9] = '{0, 0, 1, 0, 1, 0, 1, 0, 1};
    logic [31:0] epcf[9] = '{0, 0, 32'h3000, 0, 32'h3004, 0, 32'h3008, 0, 32'h300C};
    do_reset(1);
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if (imem_req !== ereq[k] || (ereq[k] && imem_addr !== eadr[k])) begin
        failures++;
        $display("FAIL seq_fetch step %0d: req=%b addr=%h, required req=%b addr=%h",
                 k, imem_req, imem_addr, ereq[k], eadr[k]);
      end
      checks++;
      if (valid_f !== evld[k] || (evld[k] && (pc_f !== epcf[k] || instr_f !== mem_word(epcf[k]))))
      begin
        failures++;
        $display("FAIL seq_fd step %0d: valid=%b pc_f=%h instr=%h, required valid=%b pc_f=%h",
                 k, valid_f, pc_f, instr_f, evld[k], epcf[k]);
      end
    end
  endtask

  task automatic test_skid();
    bit          ereq[9] = '{1, 0, 1, 0, 0, 0, 1, 0, 1};
    logic [31:0] eadr[9] = '{32'h3000, 0, 32'h3004, 0, 0, 0, 32'h3008, 0, 32'h300C};
    bit          evld[9] = '{0, 0, 1, 1, 1, 1, 1, 0, 1};
    logic [31:0] epcf[9] = '{0, 0, 32'h3000, 32'h3000, 32'h3000, 32'h3000, 32'h3004, 0, 32'h3008};
    bit          dstl[9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
    do_reset(1);
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if (imem_req !== ereq[k] || (ereq[k] && imem_addr !== eadr[k])) begin
        failures++;
        $display("FAIL skid_fetch step %0d: req=%b addr=%h, required req=%b addr=%h",
                 k, imem_req, imem_addr, ereq[k], eadr[k]);
      end
      checks++;
      if (valid_f !== evld[k] || (evld[k] && (pc_f !== epcf[k] || instr_f !== mem_word(epcf[k]))))
      begin
        failures++;
        $display("FAIL skid_fd step %0d: valid=%b pc_f=%h instr=%h, required valid=%b pc_f=%h",
                 k, valid_f, pc_f, instr_f, evld[k], epcf[k]);
      end
      stall_i = dstl[k];
    end
    stall_i = 1'b0;
  endtask

  task automatic test_branch();
    bit          ereq[9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
    logic [31:0] eadr[9] = '{32'h3000, 0, 32'h3004, 0, 32'h3008, 0, 32'h3100, 0, 32'h3104};
    bit          evld[9] = '{0, 0, 1, 0, 1, 0, 0, 0, 1};
    logic [31:0] epcf[9] = '{0, 0, 32'h3000, 0, 32'h3004, 0, 0, 0, 32'h3100};
    int          dsrc[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    do_reset(1);
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if (imem_req !== ereq[k] || (ereq[k] && imem_addr !== eadr[k])) begin
        failures++;
        $display("FAIL branch_fetch step %0d: req=%b addr=%h, required req=%b addr=%h",
                 k, imem_req, imem_addr, ereq[k], eadr[k]);
      end
      checks++;
      if (valid_f !== evld[k] || (evld[k] && (pc_f !== epcf[k] || instr_f !== mem_word(epcf[k]))))
      begin
        failures++;
        $display("FAIL branch_fd step %0d: valid=%b pc_f=%h instr=%h, required valid=%b pc_f=%h",
                 k, valid_f, pc_f, instr_f, evld[k], epcf[k]);
      end
      drive_src(dsrc[k], 32'h3100);
    end
  endtask

  task automatic test_jr();
    bit          ereq[8] = '{1, 0, 0, 1, 0, 0, 1, 0};
    logic [31:0] eadr[8] = '{32'h3000, 0, 0, 32'h3004, 0, 0, 32'h3200, 0};
    bit          evld[8] = '{0, 0, 0, 1, 0, 0, 1, 0};
    logic [31:0] epcf[8] = '{0, 0, 0, 32'h3000, 0, 0, 32'h3004, 0};
    int          dsrc[8] = '{0, 0, 0, 0, 3, 0, 0, 0};
    do_reset(2);
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (imem_req !== ereq[k] || (ereq[k] && imem_addr !== eadr[k])) begin
        failures++;
        $display("FAIL jr_fetch step %0d: req=%b addr=%h, required req=%b addr=%h",
                 k, imem_req, imem_addr, ereq[k], eadr[k]);
      end
      checks++;
      if (valid_f !== evld[k] || (evld[k] && (pc_f !== epcf[k] || instr_f !== mem_word(epcf[k]))))
      begin
        failures++;
        $display("FAIL jr_fd step %0d: valid=%b pc_f=%h instr=%h, required valid=%b pc_f=%h",
                 k, valid_f, pc_f, instr_f, evld[k], epcf[k]);
      end
      drive_src(dsrc[k], 32'h3200);
    end
  endtask

  // Jump with the delay-slot ack on the same edge, then sequential wrap past 0xFFFFFFFC.
  task automatic test_wrap();
    bit          ereq[9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
    logic [31:0] eadr[9] = '{32'h3000, 0, 32'h3004, 0, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h4};
    bit          evld[9] = '{0, 0, 1, 0, 1, 0, 1, 0, 1};
    logic [31:0] epcf[9] = '{0, 0, 32'h3000, 0, 32'h3004, 0, 32'hFFFF_FFFC, 0, 32'h0};
    int          dsrc[9] = '{0, 0, 0, 2, 0, 0, 0, 0, 0};
    do_reset(1);
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if (imem_req !== ereq[k] || (ereq[k] && imem_addr !== eadr[k])) begin
        failures++;
        $display("FAIL wrap_fetch step %0d: req=%b addr=%h, required req=%b addr=%h",
                 k, imem_req, imem_addr, ereq[k], eadr[k]);
      end
      checks++;
      if (valid_f !== evld[k] || (evld[k] && (pc_f !== epcf[k] || instr_f !== mem_word(epcf[k]))))
      begin
        failures++;
        $display("FAIL wrap_fd step %0d: valid=%b pc_f=%h instr=%h, required valid=%b pc_f=%h",
                 k, valid_f, pc_f, instr_f, evld[k], epcf[k]);
      end
      drive_src(dsrc[k], 32'hFFFF_FFFC);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    mem_manual = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      failures++;
      $display("FAIL rmid_first: req=%b addr=%h, required 1 00003000", imem_req, imem_addr);
    end
    step();
    man_ack   = 1'b1;
    man_rdata = mem_word(32'h3000);
    step();
    man_ack = 1'b0;
    checks++;
    if (valid_f !== 1'b1 || pc_f !== 32'h3000 || imem_addr !== 32'h3004) begin
      failures++;
      $display("FAIL rmid_load: valid=%b pc_f=%h addr=%h, required 1 00003000 00003004",
               valid_f, pc_f, imem_addr);
    end
    step();
    reset_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || valid_f !== 1'b0 || pc_f !== 32'h0 || instr_f !== 32'h0) begin
      failures++;
      $display("FAIL rmid_reset: req=%b valid=%b pc_f=%h instr=%h, required all 0",
               imem_req, valid_f, pc_f, instr_f);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      failures++;
      $display("FAIL rmid_reissue: req=%b addr=%h, required 1 00003000", imem_req, imem_addr);
    end
    man_ack   = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    step();
    checks++;
    if (valid_f !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL rmid_stale: valid=%b req=%b, required 0 0", valid_f, imem_req);
    end
    man_rdata = mem_word(32'h3000);
    step();
    man_ack = 1'b0;
    checks++;
    if (valid_f !== 1'b1 || pc_f !== 32'h3000 || instr_f !== mem_word(32'h3000)) begin
      failures++;
      $display("FAIL rmid_refetch: valid=%b pc_f=%h instr=%h, required 1 00003000 %h",
               valid_f, pc_f, instr_f, mem_word(32'h3000));
    end
    mem_manual = 1'b0;
  endtask

  // Random stalls, latencies and branches; D receives instructions in program order.
  task automatic test_random();
    logic [31:0] exp_pc;
    bit          d_br;
    bit          ds_pend;
    int          d_src;
    logic [31:0] d_tgt;
    logic [31:0] ds_tgt;
    int          idle;
    int          consumed;
    do_reset(0);
    exp_pc   = 32'h3000;
    d_br     = 1'b0;
    ds_pend  = 1'b0;
    d_src    = 0;
    d_tgt    = '0;
    ds_tgt   = '0;
    idle     = 0;
    consumed = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      stall_i = ($urandom_range(0, 3) == 0);
      drive_src(d_br ? d_src : 0, d_tgt);
      idle++;
      if (!stall_i) begin
        if (d_br) begin
          ds_pend = 1'b1;
          ds_tgt  = d_tgt;
          d_br    = 1'b0;
        end
        if (valid_f) begin
          checks++;
          if (pc_f !== exp_pc || instr_f !== mem_word(exp_pc)) begin
            failures++;
            $display("FAIL rand_stream cyc %0d: pc_f=%h instr=%h, required pc_f=%h instr=%h",
                     cyc, pc_f, instr_f, exp_pc, mem_word(exp_pc));
            exp_pc = pc_f;
          end
          consumed++;
          idle = 0;
          if (ds_pend) begin
            exp_pc  = ds_tgt;
            ds_pend = 1'b0;
          end else begin
            exp_pc = exp_pc + 32'd4;
            if ($urandom_range(0, 4) == 0) begin
              d_br  = 1'b1;
              d_src = int'($urandom_range(1, 3));
              d_tgt = {$urandom(), 2'b00} >> 2 << 2;
            end
          end
        end
      end
      if (idle > 60) begin
        checks++;
        failures++;
        $display("FAIL rand_progress: no instruction delivered for %0d cycles at cyc %0d, required <= 60",
                 idle, cyc);
        break;
      end
    end
    stall_i = 1'b0;
    pcsrc_d = 2'b00;
    checks++;
    if (consumed < 200) begin
      failures++;
      $display("FAIL rand_count: delivered=%0d, required >= 200", consumed);
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_skid();
    test_branch();
    test_jr();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
